// File: rtl/parking_request_scheduler_if.sv
// Request/task bus between the request sources, the scheduler and the elevator controller.
// master = request source / elevator controller side, slave = scheduler.
interface parking_request_scheduler_if #(
    parameter int DEPTH   = 4,
    parameter int PLATE_W = 16
);
    logic [PLATE_W-1:0]      license_plate;
    logic                    in_mode;
    logic                    out_mode;
    logic                    leakage;
    logic [2:0]              leakage_floor;
    logic                    task_done;
    logic                    todo_exists;
    logic                    todo_in;
    logic                    todo_out;
    logic                    todo_leak_move;
    logic [PLATE_W-1:0]      todo_license_plate;
    logic [2:0]              todo_floor;
    logic [$clog2(DEPTH):0]  queue_count;
    logic                    req_drop;

    modport master (
        output license_plate, in_mode, out_mode, leakage, leakage_floor, task_done,
        input  todo_exists, todo_in, todo_out, todo_leak_move,
               todo_license_plate, todo_floor, queue_count, req_drop
    );

    modport slave (
        input  license_plate, in_mode, out_mode, leakage, leakage_floor, task_done,
        output todo_exists, todo_in, todo_out, todo_leak_move,
               todo_license_plate, todo_floor, queue_count, req_drop
    );
endinterface

// File: rtl/parking_request_scheduler.sv
// Parking-lot request scheduler: in/out FIFO plus a leakage priority slot, one task at a time.
// Optional macro DUP_PLATE_FILTER_EN drops in/out requests whose plate is already queued or active.
//
//  state | meaning
//  IDLE  | no active task; dispatches leakage first, else FIFO head
//  BUSY  | todo_* held stable until task_done
module parking_request_scheduler #(
    parameter int DEPTH   = 4,
    parameter int PLATE_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    parking_request_scheduler_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [PLATE_W-1:0] r_fifo_plate [DEPTH];
    logic               r_fifo_out   [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               r_leak_pending;
    logic [2:0]         r_leak_floor;

    logic [0:0]         r_state;
    logic               r_todo_exists;
    logic               r_todo_in;
    logic               r_todo_out;
    logic               r_todo_leak_move;
    logic [PLATE_W-1:0] r_todo_plate;
    logic [2:0]         r_todo_floor;
    logic               r_req_drop;

    logic w_req_valid;
    logic w_req_bad;
    logic w_full;
    logic w_pop;
    logic w_dup;
    logic w_push;
    logic w_leak_ok;
    logic w_leak_bad;
    logic w_drop;

    assign w_req_valid = (bus.in_mode ^ bus.out_mode) && (bus.license_plate != '0);
    assign w_req_bad   = (bus.in_mode || bus.out_mode) && !w_req_valid;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = (r_state == S_IDLE) && !r_leak_pending && (r_count != '0);
    assign w_leak_ok   = bus.leakage && (bus.leakage_floor != 3'd0);
    assign w_leak_bad  = bus.leakage && (bus.leakage_floor == 3'd0);

`ifdef DUP_PLATE_FILTER_EN
    // An entry is valid when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [AW-1:0] w_off;
        w_off = '0;
        w_dup = r_todo_exists && !r_todo_leak_move && (r_todo_plate == bus.license_plate);
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && (r_fifo_plate[i] == bus.license_plate))
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // A full FIFO still accepts a push on the edge it pops.
    assign w_push = w_req_valid && !w_dup && (!w_full || w_pop);
    assign w_drop = w_req_bad || (w_req_valid && !w_push) || w_leak_bad;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_plate[r_wr_ptr] <= bus.license_plate;
            r_fifo_out[r_wr_ptr]   <= bus.out_mode;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_leak_pending   <= 1'b0;
            r_leak_floor     <= 3'd0;
            r_state          <= S_IDLE;
            r_todo_exists    <= 1'b0;
            r_todo_in        <= 1'b0;
            r_todo_out       <= 1'b0;
            r_todo_leak_move <= 1'b0;
            r_todo_plate     <= '0;
            r_todo_floor     <= 3'd0;
            r_req_drop       <= 1'b0;
        end else begin
            r_req_drop <= w_drop;

            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (r_leak_pending) begin
                        r_todo_exists    <= 1'b1;
                        r_todo_leak_move <= 1'b1;
                        r_todo_floor     <= r_leak_floor;
                        r_todo_plate     <= '0;
                        r_leak_pending   <= 1'b0;
                        r_state          <= S_BUSY;
                    end else if (w_pop) begin
                        r_todo_exists <= 1'b1;
                        r_todo_in     <= !r_fifo_out[r_rd_ptr];
                        r_todo_out    <= r_fifo_out[r_rd_ptr];
                        r_todo_plate  <= r_fifo_plate[r_rd_ptr];
                        r_state       <= S_BUSY;
                    end
                end
                default: begin
                    if (bus.task_done) begin
                        r_todo_exists    <= 1'b0;
                        r_todo_in        <= 1'b0;
                        r_todo_out       <= 1'b0;
                        r_todo_leak_move <= 1'b0;
                        r_todo_plate     <= '0;
                        r_todo_floor     <= 3'd0;
                        r_state          <= S_IDLE;
                    end
                end
            endcase

            // Placed after the FSM so a leakage arriving on the dispatch edge stays pending.
            if (w_leak_ok) begin
                r_leak_pending <= 1'b1;
                r_leak_floor   <= bus.leakage_floor;
            end
        end
    end

    assign bus.todo_exists        = r_todo_exists;
    assign bus.todo_in            = r_todo_in;
    assign bus.todo_out           = r_todo_out;
    assign bus.todo_leak_move     = r_todo_leak_move;
    assign bus.todo_license_plate = r_todo_plate;
    assign bus.todo_floor         = r_todo_floor;
    assign bus.queue_count        = r_count;
    assign bus.req_drop           = r_req_drop;
endmodule

// File: tb/tb_parking_request_scheduler.sv
// Directed bench for parking_request_scheduler; build with +define+DUP_PLATE_FILTER_EN to cover the duplicate filter.
module tb_parking_request_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    parking_request_scheduler_if #(.DEPTH(4), .PLATE_W(16)) bus ();

    parking_request_scheduler #(.DEPTH(4), .PLATE_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic im, input logic om, input logic [15:0] p);
        bus.in_mode       = im;
        bus.out_mode      = om;
        bus.license_plate = p;
        tick();
        bus.in_mode       = 1'b0;
        bus.out_mode      = 1'b0;
        bus.license_plate = 16'h0;
    endtask

    task automatic leak(input logic [2:0] f);
        bus.leakage       = 1'b1;
        bus.leakage_floor = f;
        tick();
        bus.leakage       = 1'b0;
        bus.leakage_floor = 3'd0;
    endtask

    task automatic done_pulse();
        bus.task_done = 1'b1;
        tick();
        bus.task_done = 1'b0;
    endtask

    task automatic chk_task(input string tag, input logic ex, input logic ti, input logic to,
                            input logic tl, input logic [15:0] p, input logic [2:0] f);
        chk({tag, ".exists"}, 32'(bus.todo_exists), 32'(ex));
        chk({tag, ".in"},     32'(bus.todo_in), 32'(ti));
        chk({tag, ".out"},    32'(bus.todo_out), 32'(to));
        chk({tag, ".leak"},   32'(bus.todo_leak_move), 32'(tl));
        chk({tag, ".plate"},  32'(bus.todo_license_plate), 32'(p));
        chk({tag, ".floor"},  32'(bus.todo_floor), 32'(f));
    endtask

    logic [15:0] exp4 [4];

    initial begin
        bus.license_plate = 16'h0;
        bus.in_mode       = 1'b0;
        bus.out_mode      = 1'b0;
        bus.leakage       = 1'b0;
        bus.leakage_floor = 3'd0;
        bus.task_done     = 1'b0;
        exp4 = '{16'h3851, 16'h9522, 16'h9532, 16'h1111};

        tick(); tick();
        reset = 1'b0;
        chk_task("rst", 0, 0, 0, 0, 16'h0, 3'd0);
        chk("rst.qc", 32'(bus.queue_count), 0);
        chk("rst.drop", 32'(bus.req_drop), 0);

        // 1: single entry request, latency and completion
        req(1, 0, 16'h9423);
        chk("t1.qc_push", 32'(bus.queue_count), 1);
        chk("t1.exists_e", 32'(bus.todo_exists), 0);
        tick();
        chk_task("t1.disp", 1, 1, 0, 0, 16'h9423, 3'd0);
        chk("t1.qc_pop", 32'(bus.queue_count), 0);
        tick();
        chk_task("t1.hold", 1, 1, 0, 0, 16'h9423, 3'd0);
        done_pulse();
        chk_task("t1.done", 0, 0, 0, 0, 16'h0, 3'd0);

        // 2: queued while busy, one idle gap
        req(1, 0, 16'h9423);
        tick();
        req(1, 0, 16'h8754);
        chk("t2.qc", 32'(bus.queue_count), 1);
        chk_task("t2.busy", 1, 1, 0, 0, 16'h9423, 3'd0);
        done_pulse();
        chk("t2.gap", 32'(bus.todo_exists), 0);
        chk("t2.gap_qc", 32'(bus.queue_count), 1);
        tick();
        chk_task("t2.next", 1, 1, 0, 0, 16'h8754, 3'd0);
        chk("t2.qc0", 32'(bus.queue_count), 0);
        done_pulse();

        // 3: leakage overtakes queued exit
        req(1, 0, 16'h5755);
        tick();
        req(0, 1, 16'h8754);
        leak(3'd3);
        chk("t3.qc", 32'(bus.queue_count), 1);
        done_pulse();
        chk("t3.gap", 32'(bus.todo_exists), 0);
        tick();
        chk_task("t3.leak", 1, 0, 0, 1, 16'h0, 3'd3);
        chk("t3.qc_keep", 32'(bus.queue_count), 1);
        done_pulse();
        tick();
        chk_task("t3.out", 1, 0, 1, 0, 16'h8754, 3'd0);
        done_pulse();

        // 4: overflow with DEPTH=4, FIFO order preserved
        req(1, 0, 16'hAAAA);
        tick();
        req(1, 0, 16'h3851);
        req(0, 1, 16'h9522);
        req(1, 0, 16'h9532);
        req(0, 1, 16'h1111);
        chk("t4.qc4", 32'(bus.queue_count), 4);
        chk("t4.nodrop", 32'(bus.req_drop), 0);
        req(1, 0, 16'h2222);
        chk("t4.drop", 32'(bus.req_drop), 1);
        chk("t4.qc_full", 32'(bus.queue_count), 4);
        tick();
        chk("t4.drop_end", 32'(bus.req_drop), 0);
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            tick();
            chk($sformatf("t4.order%0d", i), 32'(bus.todo_license_plate), 32'(exp4[i]));
            chk($sformatf("t4.out%0d", i), 32'(bus.todo_out), 32'(i % 2));
        end
        done_pulse();
        tick();
        chk("t4.empty", 32'(bus.todo_exists), 0);
        chk("t4.qc0", 32'(bus.queue_count), 0);

        // 5: illegal requests, idle task_done ignored
        req(1, 1, 16'h1234);
        chk("t5.both", 32'(bus.req_drop), 1);
        chk("t5.both_qc", 32'(bus.queue_count), 0);
        req(1, 0, 16'h0000);
        chk("t5.zero", 32'(bus.req_drop), 1);
        chk("t5.zero_qc", 32'(bus.queue_count), 0);
        leak(3'd0);
        chk("t5.floor0", 32'(bus.req_drop), 1);
        tick();
        chk("t5.drop_end", 32'(bus.req_drop), 0);
        chk("t5.notask", 32'(bus.todo_exists), 0);
        done_pulse();
        tick();
        chk("t5.idle_done", 32'(bus.todo_exists), 0);

        // 6: reset mid-task with queued entries
        req(1, 0, 16'h1001);
        tick();
        req(1, 0, 16'h1002);
        req(0, 1, 16'h1003);
        req(1, 0, 16'h1004);
        chk("t6.qc3", 32'(bus.queue_count), 3);
        reset = 1'b1;
        bus.task_done = 1'b1;
        tick();
        bus.task_done = 1'b0;
        chk_task("t6.rst", 0, 0, 0, 0, 16'h0, 3'd0);
        chk("t6.qc", 32'(bus.queue_count), 0);
        reset = 1'b0;
        tick();
        chk("t6.after", 32'(bus.todo_exists), 0);

`ifdef DUP_PLATE_FILTER_EN
        req(1, 0, 16'h9423);
        tick();
        req(1, 0, 16'h9423);
        chk("dup.drop1", 32'(bus.req_drop), 1);
        chk("dup.qc1", 32'(bus.queue_count), 0);
        req(1, 0, 16'h9423);
        chk("dup.drop2", 32'(bus.req_drop), 1);
        req(0, 1, 16'h4444);
        req(1, 0, 16'h4444);
        chk("dup.fifo_drop", 32'(bus.req_drop), 1);
        chk("dup.qc", 32'(bus.queue_count), 1);
        done_pulse();
`else
        req(1, 0, 16'h9423);
        tick();
        req(1, 0, 16'h9423);
        chk("dup.nodrop", 32'(bus.req_drop), 0);
        chk("dup.qc", 32'(bus.queue_count), 1);
        done_pulse();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
